imem_dmem_port_arbiter: RTL and testbench
=========================================

// Module: imem_dmem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between instruction fetch (IF) and the data stage (MEM).
//  Issues one transaction at a time and returns a completion strobe plus read data to the owner.
//  Produces the pipeline stall/freeze controls that sit beside the forwarding and hazard logic.
//  Provides a fetch-abort path for taken branches and a watchdog on memory latency.
// PARAMETERS
//  ADDR_W   32   address width, both requesters and the memory port
//  DATA_W   32   data width; byte enables are DATA_W/8 bits
//  TIMEOUT  64   max cycles mem_req may wait for mem_ready before abort (>=2)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  if_req     in   1        fetch request, level, held until if_done
//  if_addr    in   ADDR_W   fetch address (PC)
//  if_done    out  1        fetch complete this cycle (combinational)
//  if_rdata   out  DATA_W   instruction, valid when if_done
//  flush      in   1        taken branch/jump: discard outstanding fetch
//  dm_req     in   1        data request, level, held until dm_done
//  dm_we      in   1        1 = store, 0 = load
//  dm_be      in   DATA_W/8 store byte enables
//  dm_addr    in   ADDR_W   data address
//  dm_wdata   in   DATA_W   store data
//  dm_done    out  1        data access complete this cycle (combinational)
//  dm_rdata   out  DATA_W   load data, valid when dm_done
//  mem_req    out  1        memory transaction active (registered)
//  mem_we     out  1        registered, mirrors the granted request
//  mem_be     out  DATA_W/8 registered; all ones for fetch
//  mem_addr   out  ADDR_W   registered, held stable while mem_req
//  mem_wdata  out  DATA_W   registered, held stable while mem_req
//  mem_ready  in   1        memory completes the current transaction
//  mem_rdata  in   DATA_W   memory read data, valid with mem_ready
//  pipe_stall out  1        freeze PC, IF/ID, ID/EX, EX/MEM = dm_req & ~dm_done
//  if_stall   out  1        hold PC/IF-ID = pipe_stall | (if_req & ~if_done)
//  bus_err    out  1        sticky: a transaction hit TIMEOUT; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, watchdog, bus_err = 0.
//   All done/stall outputs are then 0 because requests are low.
//  FSM states: IDLE, FETCH, DATA, DRAIN.
//  IDLE:
//   dm_req -> latch dm_* into mem_*, go DATA. Data wins when both requests are high.
//   else if_req & ~flush -> latch if_addr, we=0, be=all ones, go FETCH.
//  FETCH/DATA: mem_req=1; if_done/dm_done = mem_ready; rdata passes mem_rdata through.
//  Latency: grant edge, then >=1 wait cycle; the done cycle is the first cycle mem_ready=1.
//   Minimum is 2 cycles from request to done.
//  Chaining on completion (mem_ready=1), the completing requester is ignored that cycle:
//   DATA done  -> FETCH if if_req & ~flush (latch new if_addr), else IDLE.
//   FETCH done -> DATA if dm_req, else IDLE. This alternation prevents starvation.
//  Flush:
//   FETCH & flush & ~mem_ready -> DRAIN; mem_req stays 1 (no abort); if_done suppressed.
//   FETCH & flush & mem_ready -> if_done=0, go IDLE.
//   DRAIN & mem_ready -> IDLE, no done strobe.
//   Flush in IDLE blocks a fetch grant that cycle; flush has no effect in DATA.
//  Watchdog:
//   Counts cycles in FETCH/DATA/DRAIN with ~mem_ready; cleared on each grant/completion.
//   At TIMEOUT: set bus_err, pulse the owner's done with rdata = 0, mem_req -> 0, go IDLE.
//  Reset mid-transaction: immediate return to reset values; no done strobe.
// STRUCTURE
//  Shared package femto_pkg: ADDR_W/DATA_W defaults, arbiter state encoding (2-bit), BE_ALL.
//  One sub-module, arb_watchdog: counter with clear/enable, expires at TIMEOUT.
//  The rest is one FSM and its registered mem_* bank.
// TESTING
//  1. Fetch only: if_req=1, addr 0x100, mem_ready two cycles after grant.
//     -> mem_addr=0x100, be=0xF; if_done in the 3rd cycle with if_rdata=mem_rdata.
//  2. Same-cycle if_req and dm_req (load 0x2000).
//     -> DATA granted first; pipe_stall=1 until dm_done; then FETCH in the next cycle.
//  3. Store dm_be=0x3, wdata 0xDEADBEEF, ready one cycle after grant.
//     -> mem_we=1, mem_be=0x3, dm_done 2 cycles after dm_req.
//  4. Flush one cycle into a fetch, ready 3 cycles later.
//     -> DRAIN, if_done never asserts, mem_req drops after ready.
//     -> a new fetch with the new PC is granted next.
//  5. mem_ready held low, TIMEOUT=8.
//     -> done strobes at wait 8 with rdata=0; bus_err=1 and stays set until rst=0.
//  6. rst asserted low in DATA.
//     -> mem_req=0 asynchronously, state IDLE, no dm_done; normal grants after release.

Source files
------------

// File: rtl/femto_pkg.sv
// Shared definitions for the unified memory-port arbiter: default widths,
// arbiter state encoding and the fetch byte-enable pattern.
package femto_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // All lanes enabled; fetches always read a full word.
    localparam logic [DATA_W_DEF/8-1:0] BE_ALL = '1;

    // IDLE: port free. FETCH/DATA: transaction owned by IF/MEM.
    // DRAIN: a flushed fetch is still in flight and its result is discarded.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Memory-latency watchdog: counts waiting cycles and flags the cycle in
// which the TIMEOUT-th consecutive wait occurs.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Wait counter; clear has priority so a grant/completion restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt holds the number of earlier waits, so this is the TIMEOUT-th one.
    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the data
// stage. One transaction at a time, registered mem_* bank, combinational
// completion strobes, pipeline stall outputs, fetch flush and a watchdog.
//
// Handshake: a requester raises *_req and holds it (with its address/data)
// until *_done is seen high; *_done is a single-cycle strobe in the cycle
// the memory returns mem_ready (or the watchdog expires), and *_rdata is
// only meaningful in that cycle. On the memory side mem_req stays high with
// stable mem_* fields until the first cycle mem_ready=1 completes it.
import femto_pkg::*;

module imem_dmem_port_arbiter #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                flush,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_done,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                pipe_stall,
    output logic                if_stall,
    output logic                bus_err,
    output arb_state_t          dbg_state
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] BE_FETCH = '1;

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              grant_if;
    logic              grant_dm;
    logic              busy;
    logic              expired;
    logic [DATA_W-1:0] rdata_mux;

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!busy || mem_ready),
        .en      (busy && !mem_ready),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grants; on completion the finishing requester is
    // skipped so IF and MEM alternate instead of one starving the other.
    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dm_req) begin
                    state_d  = ST_DATA;
                    grant_dm = 1'b1;
                end else if (if_req && !flush) begin
                    state_d  = ST_FETCH;
                    grant_if = 1'b1;
                end
            end
            ST_FETCH: begin
                if (expired) begin
                    state_d = ST_IDLE;
                end else if (mem_ready) begin
                    if (!flush && dm_req) begin
                        state_d  = ST_DATA;
                        grant_dm = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DATA: begin
                if (expired) begin
                    state_d = ST_IDLE;
                end else if (mem_ready) begin
                    if (if_req && !flush) begin
                        state_d  = ST_FETCH;
                        grant_if = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (expired || mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion strobes; a watchdog abort returns zero data to the owner.
    always_comb begin
        if_done   = 1'b0;
        dm_done   = 1'b0;
        rdata_mux = expired ? '0 : mem_rdata;
        case (state_q)
            ST_FETCH: if_done = (mem_ready || expired) && !flush;
            ST_DATA:  dm_done = mem_ready || expired;
            default:  ;
        endcase
    end

    assign if_rdata   = rdata_mux;
    assign dm_rdata   = rdata_mux;
    assign pipe_stall = dm_req && !dm_done;
    assign if_stall   = pipe_stall || (if_req && !if_done);

    // Registered memory-port bank; fields only change on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (state_d != ST_IDLE);
            if (grant_dm) begin
                mem_we    <= dm_we;
                mem_be    <= dm_be;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_we    <= 1'b0;
                mem_be    <= BE_FETCH;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end
    end

    // Sticky bus error, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err <= 1'b0;
        end else if (expired) begin
            bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Bench for imem_dmem_port_arbiter: directed scenarios followed by random
// requester/memory traffic, every cycle checked against a transaction-level
// reference model.
module tb_imem_dmem_port_arbiter;
  import femto_pkg::*;

  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [3:0]  dm_be = '0;
  logic        if_done, dm_done, mem_req, mem_we, pipe_stall, if_stall, bus_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  arb_state_t  dbg_state;

  imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .flush(flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pipe_stall(pipe_stall), .if_stall(if_stall), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction: who owns it, whether a flush turned it
  // into a discarded fetch, how many cycles it has waited, and its fields.
  bit          m_busy, m_data, m_discard, m_err;
  int          m_wait;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        e_if_done = 1'b0, e_dm_done = 1'b0;
  logic        o_if_done = 1'b0, o_dm_done = 1'b0;

  task automatic model_reset();
    m_busy = 0; m_data = 0; m_discard = 0; m_err = 0; m_wait = 0;
    m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic start_fetch();
    m_busy = 1; m_data = 0; m_discard = 0; m_wait = 0;
    m_we = 0; m_be = 4'hF; m_addr = if_addr; m_wdata = '0;
  endtask

  task automatic start_data();
    m_busy = 1; m_data = 1; m_discard = 0; m_wait = 0;
    m_we = dm_we; m_be = dm_be; m_addr = dm_addr; m_wdata = dm_wdata;
  endtask

  // One clock: compare at the falling edge, then advance the model and
  // return 1 time unit after the rising edge so callers can drive inputs.
  task automatic step();
    bit          expired, finishing, ps;
    logic [31:0] exp_rdata;
    @(negedge clk);
    expired   = m_busy && !mem_ready && (m_wait == TO - 1);
    finishing = m_busy && (mem_ready || expired);
    e_if_done = finishing && !m_data && !m_discard && !flush;
    e_dm_done = finishing && m_data;
    exp_rdata = expired ? 32'h0 : mem_rdata;
    o_if_done = if_done;
    o_dm_done = dm_done;
    chk("if_done", 32'(if_done), 32'(e_if_done));
    chk("dm_done", 32'(dm_done), 32'(e_dm_done));
    if (e_if_done) chk("if_rdata", if_rdata, exp_rdata);
    if (e_dm_done) chk("dm_rdata", dm_rdata, exp_rdata);
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_be", 32'(mem_be), 32'(m_be));
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    ps = dm_req && !e_dm_done;
    chk("pipe_stall", 32'(pipe_stall), 32'(ps));
    chk("if_stall", 32'(if_stall), 32'(ps || (if_req && !e_if_done)));
    chk("bus_err", 32'(bus_err), 32'(m_err));
    if (!m_busy) begin
      if (dm_req) start_data();
      else if (if_req && !flush) start_fetch();
    end else if (finishing) begin
      if (expired) begin
        m_err = 1; m_busy = 0;
      end else if (m_data) begin
        if (if_req && !flush) start_fetch(); else m_busy = 0;
      end else if (m_discard || flush) begin
        m_busy = 0;
      end else if (dm_req) begin
        start_data();
      end else begin
        m_busy = 0;
      end
    end else begin
      m_wait++;
      if (!m_data && flush) m_discard = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic new_dm();
    dm_req   = 1'b1;
    dm_we    = 1'($urandom_range(0, 1));
    dm_be    = 4'($urandom_range(0, 15));
    dm_addr  = $urandom & 32'hFFFF_FFFC;
    dm_wdata = $urandom;
  endtask

  // Pipeline-like requesters: hold requests until done, occasional flushes.
  task automatic drive_random();
    if (dm_req && e_dm_done) dm_req = 1'b0;
    if (!dm_req && $urandom_range(0, 3) == 0) new_dm();
    if (if_req && e_if_done) begin
      if_addr = if_addr + 32'd4;
      if_req  = ($urandom_range(0, 4) != 0);
    end else if (!if_req && $urandom_range(0, 1) == 0) begin
      if_req = 1'b1;
    end
    flush = if_req && ($urandom_range(0, 9) == 0);
    if (flush) if_addr = $urandom & 32'hFFFF_FFFC;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_stalls", 32'({pipe_stall, if_stall, if_done, dm_done}), 32'h0);
    #1 rst = 1'b1;

    // 1: plain fetch, ready two cycles after the grant
    if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h13;
    step();
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_be", 32'(mem_be), 32'hF);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h00A0_0093;
    step();
    chk("t1_done_3rd", 32'(o_if_done), 32'h1);
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    // 2: simultaneous requests, data first then fetch
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h2000; dm_wdata = '0;
    step();
    chk("t2_state", 32'(dbg_state), 32'(ST_DATA));
    chk("t2_addr", mem_addr, 32'h2000);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    chk("t2_dm_done", 32'(o_dm_done), 32'h1);
    chk("t2_then_fetch", 32'(dbg_state), 32'(ST_FETCH));
    chk("t2_fetch_addr", mem_addr, 32'h104);
    dm_req = 1'b0;
    step();
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    // 3: byte-enabled store, ready one cycle after the grant
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h3; dm_addr = 32'h3000; dm_wdata = 32'hDEAD_BEEF;
    step();
    chk("t3_we", 32'(mem_we), 32'h1);
    chk("t3_be", 32'(mem_be), 32'h3);
    chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ready = 1'b1;
    step();
    chk("t3_done", 32'(o_dm_done), 32'h1);
    dm_req = 1'b0; mem_ready = 1'b0;
    step();

    // 4: flush one cycle into a fetch, then refetch from the new PC
    if_req = 1'b1; if_addr = 32'h200;
    step();
    flush = 1'b1; if_addr = 32'h400;
    step();
    chk("t4_drain", 32'(dbg_state), 32'(ST_DRAIN));
    flush = 1'b0;
    step();
    step();
    mem_ready = 1'b1;
    step();
    chk("t4_no_done", 32'(o_if_done), 32'h0);
    chk("t4_req_drop", 32'(mem_req), 32'h0);
    mem_ready = 1'b0;
    step();
    chk("t4_new_pc", mem_addr, 32'h400);
    mem_ready = 1'b1;
    step();
    chk("t4_refetch_done", 32'(o_if_done), 32'h1);
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    // 6: reset asserted in the middle of a data access
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h5000;
    step();
    chk("t6_in_data", 32'(dbg_state), 32'(ST_DATA));
    #2 rst = 1'b0;
    #1;
    chk("t6_async_req", 32'(mem_req), 32'h0);
    chk("t6_async_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_no_done", 32'(dm_done), 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    step();
    chk("t6_regrant", 32'(dbg_state), 32'(ST_DATA));
    mem_ready = 1'b1;
    step();
    chk("t6_done", 32'(o_dm_done), 32'h1);
    dm_req = 1'b0; mem_ready = 1'b0;
    step();

    // random traffic
    repeat (1500) begin
      drive_random();
      step();
    end
    if_req = 1'b0; dm_req = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    repeat (3) step();
    mem_ready = 1'b0;

    // 5: memory never answers; watchdog aborts at the 8th wait
    do_reset();
    chk("t5_err_clear", 32'(bus_err), 32'h0);
    if_req = 1'b1; if_addr = 32'h600; mem_rdata = 32'hFFFF_FFFF;
    step();
    for (int k = 1; k <= TO; k++) begin
      step();
      chk("t5_done_timing", 32'(o_if_done), 32'(k == TO));
    end
    if_req = 1'b0;
    chk("t5_bus_err", 32'(bus_err), 32'h1);
    chk("t5_req_low", 32'(mem_req), 32'h0);
    repeat (3) step();
    chk("t5_err_sticky", 32'(bus_err), 32'h1);
    do_reset();
    chk("t5_err_rst", 32'(bus_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
